// File: rtl/mem_access_pkg.sv
// Shared encodings and decode helpers for the MEM-stage access unit.
package mem_access_pkg;

   localparam logic [3:0] MEM_OP_NOP  = 4'd0;
   localparam logic [3:0] MEM_OP_LDB  = 4'd1;
   localparam logic [3:0] MEM_OP_LDBU = 4'd2;
   localparam logic [3:0] MEM_OP_LDH  = 4'd3;
   localparam logic [3:0] MEM_OP_LDHU = 4'd4;
   localparam logic [3:0] MEM_OP_LDW  = 4'd5;
   localparam logic [3:0] MEM_OP_STB  = 4'd6;
   localparam logic [3:0] MEM_OP_STH  = 4'd7;
   localparam logic [3:0] MEM_OP_STW  = 4'd8;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;

   function automatic logic is_mem(input logic [3:0] op);
      return (op >= MEM_OP_LDB) && (op <= MEM_OP_STW);
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return (op >= MEM_OP_LDB) && (op <= MEM_OP_LDW);
   endfunction

   function automatic logic op_signed(input logic [3:0] op);
      return (op == MEM_OP_LDB) || (op == MEM_OP_LDH);
   endfunction

   function automatic logic [1:0] op_size(input logic [3:0] op);
      case (op)
         MEM_OP_LDB, MEM_OP_LDBU, MEM_OP_STB: return SZ_B;
         MEM_OP_LDH, MEM_OP_LDHU, MEM_OP_STH: return SZ_H;
         default:                             return SZ_W;
      endcase
   endfunction

   function automatic logic is_aligned(input logic [3:0] op,
                                       input logic [1:0] off);
      case (op_size(op))
         SZ_H:    return ~off[0];
         SZ_W:    return off == 2'd0;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_sgn,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be_,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [1:0]  w_lane_b;
   logic [1:0]  w_lane_h;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane index counts byte positions from bit 0 upward.
   assign w_lane_b = BIG_ENDIAN ? 2'd3 - i_off : i_off;
   assign w_lane_h = {BIG_ENDIAN ? ~i_off[1] : i_off[1], 1'b0};

   always_comb begin
      w_byte = i_rdata[7:0];
      case (w_lane_b)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   assign w_half = w_lane_h[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_be_   = ~LANE_W;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (i_size)
         SZ_B: begin
            o_be_   = ~(LANE_B << w_lane_b);
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_sgn & w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            o_be_   = ~(LANE_H << w_lane_h);
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{i_sgn & w_half[15]}}, w_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: sized loads/stores over a wait-state bus
// with timeout, stalling the pipeline until the access completes.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W     = 30,
   parameter int TIMEOUT    = 255,
   parameter int TO_W       = 8,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              ex_en,
   input  logic [3:0]        ex_mem_op,
   input  logic [31:0]       ex_mem_wr_data,
   input  logic [31:0]       ex_out,
   input  logic [31:0]       rd_data,
   input  logic              rdy_,
   output logic [ADDR_W-1:0] addr,
   output logic              as_,
   output logic              rw,
   output logic [3:0]        be_,
   output logic [31:0]       wr_data,
   output logic [31:0]       out,
   output logic              done,
   output logic              miss_align,
   output logic              bus_err,
   output logic              busy
);

   state_t            r_state, w_next;
   logic [TO_W-1:0]   r_cnt;
   logic [3:0]        r_op;
   logic [1:0]        r_off;

   logic              w_is_mem, w_ok, w_accept, w_to;
   logic [3:0]        w_op;
   logic [1:0]        w_off;
   logic [3:0]        w_be_al;
   logic [31:0]       w_wr_al, w_rd_al;

   logic              w_as_, w_rw, w_done, w_miss, w_berr;
   logic [3:0]        w_be_;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wr, w_out;

   assign w_is_mem = is_mem(ex_mem_op);
   assign w_ok     = is_aligned(ex_mem_op, ex_out[1:0]);
   assign w_accept = (r_state == ST_IDLE) & ex_en & w_is_mem & w_ok;
   assign w_to     = r_cnt == TO_W'(TIMEOUT - 1);
   assign busy     = (r_state == ST_BUSY) | w_accept;

   // Store path decodes the live request; load path the latched one.
   assign w_op  = (r_state == ST_BUSY) ? r_op  : ex_mem_op;
   assign w_off = (r_state == ST_BUSY) ? r_off : ex_out[1:0];

   mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .i_off   (w_off),
      .i_size  (op_size(w_op)),
      .i_sgn   (op_signed(w_op)),
      .i_wdata (ex_mem_wr_data),
      .i_rdata (rd_data),
      .o_be_   (w_be_al),
      .o_wdata (w_wr_al),
      .o_rdata (w_rd_al)
   );

   always_ff @(posedge clk) begin
      if (!reset_) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_BUSY;
         ST_BUSY: if (!rdy_ || w_to) w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_as_  = as_;
      w_rw   = rw;
      w_be_  = be_;
      w_addr = addr;
      w_wr   = wr_data;
      w_out  = out;
      w_done = 1'b0;
      w_miss = 1'b0;
      w_berr = 1'b0;
      unique case (r_state)
         ST_IDLE: if (ex_en) begin
            if (!w_is_mem) begin
               w_out  = ex_out;
               w_done = 1'b1;
            end else if (!w_ok) begin
               w_out  = '0;
               w_done = 1'b1;
               w_miss = 1'b1;
            end else begin
               w_as_  = ENABLE_;
               w_rw   = is_load(ex_mem_op) ? READ : WRITE;
               w_be_  = w_be_al;
               w_addr = ex_out[ADDR_W+1:2];
               w_wr   = w_wr_al;
            end
         end
         // rdy_ is tested first so a same-edge ready beats the timeout.
         ST_BUSY: if (!rdy_ || w_to) begin
            w_as_  = DISABLE_;
            w_rw   = READ;
            w_be_  = '1;
            w_done = 1'b1;
            w_berr = rdy_;
            w_out  = (!rdy_ && is_load(r_op)) ? w_rd_al : '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         as_        <= DISABLE_;
         rw         <= READ;
         be_        <= '1;
         addr       <= '0;
         wr_data    <= '0;
         out        <= '0;
         done       <= 1'b0;
         miss_align <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         as_        <= w_as_;
         rw         <= w_rw;
         be_        <= w_be_;
         addr       <= w_addr;
         wr_data    <= w_wr;
         out        <= w_out;
         done       <= w_done;
         miss_align <= w_miss;
         bus_err    <= w_berr;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         r_cnt <= '0;
         r_op  <= MEM_OP_NOP;
         r_off <= 2'd0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_op  <= ex_mem_op;
         r_off <= ex_out[1:0];
      end else if (r_state == ST_BUSY && rdy_ && !w_to) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
